// File: rtl/sc1_soc_if.sv
// sc1_soc_if -- board-level pins of the SC1 SoC.
//   uart_rxd : UART receive line into the SoC (idle high)
//   uart_txd : UART transmit line out of the SoC (held idle)
//   led      : 10 LED drive bits
// modport master : the board / testbench side
// modport slave  : the SoC side
interface sc1_soc_if;
    logic       uart_rxd;
    logic       uart_txd;
    logic [9:0] led;

    modport master (output uart_rxd, input uart_txd, input led);
    modport slave  (input uart_rxd, output uart_txd, output led);
endinterface

// File: rtl/sc1_soc.sv
// sc1_soc -- SC1 SoC: UART boot loader, instruction/data RAMs, IO register
// block and the sc1_cpu core.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low
//   pins  : sc1_soc_if.slave (uart_rxd in, uart_txd out, led[9:0] out)
// Loader packet: AA, addr[7:0..31:24], data[7:0..31:24], 55 (commit).
// Control addresses: 0x5000 cpu_reset, 0x5001 resume, 0x5002 master.

// sc1_cpu -- small accumulator core. Instruction: op[31:28], imm[15:0].
//   0 NOP, 1 LDI acc=imm, 2 STIO io[imm]=acc, 3 LDIO acc=io[imm],
//   4 ST mem_d[imm]=acc, 5 LD acc=mem_d[imm], 6 ADDI acc+=imm,
//   7 JMP pc=imm, F HALT (holds pc until resume is high).
// Reset is synchronous: it is a decoded control level from the SoC, not a pin.
module sc1_cpu #(
    parameter int WIDTH_D = 32,
    parameter int DEPTH_I = 12,
    parameter int DEPTH_D = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               resume,
    output logic [DEPTH_I-1:0] i_addr,
    input  logic [31:0]        i_data,
    output logic [DEPTH_D-1:0] d_addr,
    input  logic [WIDTH_D-1:0] d_rdata,
    output logic [WIDTH_D-1:0] d_wdata,
    output logic               d_we,
    output logic [4:0]         io_addr,
    input  logic [WIDTH_D-1:0] io_rdata,
    output logic [WIDTH_D-1:0] io_wdata,
    output logic               io_we
);
    typedef enum logic [1:0] {C_FETCH, C_EXEC, C_LOAD} cstate_t;

    localparam logic [3:0] OP_LDI  = 4'h1, OP_STIO = 4'h2, OP_LDIO = 4'h3,
                           OP_ST   = 4'h4, OP_LD   = 4'h5, OP_ADDI = 4'h6,
                           OP_JMP  = 4'h7, OP_HALT = 4'hF;

    cstate_t            st;
    logic [DEPTH_I-1:0] pc;
    logic [WIDTH_D-1:0] acc;
    logic [3:0]         op;
    logic [15:0]        imm;
    logic               exec;
    logic               unused_bits;

    assign op          = i_data[31:28];
    assign imm         = i_data[15:0];
    assign unused_bits = ^i_data[27:16];
    // Write strobes are gated by reset so nothing fires in the cycle reset rises.
    assign exec        = (st == C_EXEC) && !reset;

    assign i_addr   = pc;
    assign d_addr   = imm[DEPTH_D-1:0];
    assign d_wdata  = acc;
    assign d_we     = exec && (op == OP_ST);
    assign io_addr  = imm[4:0];
    assign io_wdata = acc;
    assign io_we    = exec && (op == OP_STIO);

    always_ff @(posedge clk) begin
        if (reset) begin
            st  <= C_FETCH;
            pc  <= '0;
            acc <= '0;
        end else begin
            case (st)
                // Instruction RAM read is registered: wait one cycle for i_data.
                C_FETCH: st <= C_EXEC;
                C_EXEC: begin
                    st <= C_FETCH;
                    pc <= pc + 1'b1;
                    case (op)
                        OP_LDI:  acc <= WIDTH_D'(imm);
                        OP_LDIO: acc <= io_rdata;
                        OP_ADDI: acc <= acc + WIDTH_D'(imm);
                        OP_LD:   st  <= C_LOAD;
                        OP_JMP:  pc  <= imm[DEPTH_I-1:0];
                        OP_HALT: if (!resume) pc <= pc;
                        default: ;
                    endcase
                end
                C_LOAD: begin
                    acc <= d_rdata;
                    st  <= C_FETCH;
                end
                default: st <= C_FETCH;
            endcase
        end
    end
endmodule

module sc1_soc #(
    parameter int UART_CLK_HZ  = 50000000,
    parameter int UART_SCLK_HZ = 115200,
    parameter int WIDTH_D      = 32,
    parameter int DEPTH_I      = 12,
    parameter int DEPTH_D      = 12,
    parameter int DEPTH_V      = 17
) (
    input  logic      clk,
    input  logic      reset,
    sc1_soc_if.slave  pins
);
    localparam int P    = UART_CLK_HZ / UART_SCLK_HZ;
    localparam int HALF = P / 2;
    localparam int CW   = $clog2(P + 1);
    localparam logic [31:0] I_BASE = 32'h0000_4000;

    // ---------------- UART receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic            rx_s1, rx_s2, rx_prev;
    rx_state_t       rx_st;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic [7:0]      rx_byte;
    logic            byte_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_st      <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
        end else begin
            rx_s1      <= pins.uart_rxd;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            byte_valid <= 1'b0;
            case (rx_st)
                RX_IDLE: if (rx_prev && !rx_s2) begin
                    rx_cnt <= '0;
                    rx_st  <= RX_START;
                end
                // Mid start bit: a line already back high was a glitch.
                RX_START: if (rx_cnt == CW'(HALF - 1)) begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    rx_st  <= rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
                RX_DATA: if (rx_cnt == CW'(P - 1)) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_st  <= RX_STOP;
                    else                rx_bit <= rx_bit + 1'b1;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
                RX_STOP: if (rx_cnt == CW'(P - 1)) begin
                    rx_st <= RX_IDLE;
                    if (rx_s2) begin
                        rx_byte    <= rx_shift;
                        byte_valid <= 1'b1;
                    end
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    // ---------------- Loader FSM + control registers ----------------
    typedef enum logic [3:0] {
        L_IDLE, L_A0, L_A1, L_A2, L_A3, L_D0, L_D1, L_D2, L_D3, L_END
    } ld_state_t;

    ld_state_t   ld_st;
    logic [31:0] ld_addr, ld_data;
    logic        commit;
    logic        cpu_reset, resume, master;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_st     <= L_IDLE;
            ld_addr   <= '0;
            ld_data   <= '0;
            commit    <= 1'b0;
            cpu_reset <= 1'b1;
            resume    <= 1'b0;
            master    <= 1'b0;
        end else begin
            commit <= 1'b0;
            // Control registers accept commits regardless of master.
            if (commit) begin
                case (ld_addr)
                    32'h0000_5000: cpu_reset <= ld_data[0];
                    32'h0000_5001: resume    <= ld_data[0];
                    32'h0000_5002: master    <= ld_data[0];
                    default: ;
                endcase
            end
            if (byte_valid) begin
                case (ld_st)
                    L_IDLE: if (rx_byte == 8'hAA) ld_st <= L_A0;
                    L_A0: begin ld_addr[7:0]   <= rx_byte; ld_st <= L_A1; end
                    L_A1: begin ld_addr[15:8]  <= rx_byte; ld_st <= L_A2; end
                    L_A2: begin ld_addr[23:16] <= rx_byte; ld_st <= L_A3; end
                    L_A3: begin ld_addr[31:24] <= rx_byte; ld_st <= L_D0; end
                    L_D0: begin ld_data[7:0]   <= rx_byte; ld_st <= L_D1; end
                    L_D1: begin ld_data[15:8]  <= rx_byte; ld_st <= L_D2; end
                    L_D2: begin ld_data[23:16] <= rx_byte; ld_st <= L_D3; end
                    L_D3: begin ld_data[31:24] <= rx_byte; ld_st <= L_END; end
                    L_END: begin
                        commit <= (rx_byte == 8'h55);
                        ld_st  <= L_IDLE;
                    end
                    default: ld_st <= L_IDLE;
                endcase
            end
        end
    end

    // ---------------- RAMs with master-selected ownership ----------------
    logic [DEPTH_I-1:0] cpu_i_addr;
    logic [DEPTH_D-1:0] cpu_d_addr;
    logic [WIDTH_D-1:0] cpu_d_wdata;
    logic               cpu_d_we;
    logic [31:0]        i_rdata;
    logic [WIDTH_D-1:0] d_rdata;
    logic [31:0]        i_off;
    logic               ld_i_hit, ld_d_hit;
    logic [DEPTH_I-1:0] mi_addr;
    logic               mi_we;
    logic [DEPTH_D-1:0] md_addr;
    logic [WIDTH_D-1:0] md_wdata;
    logic               md_we;

    logic [31:0]        mem_i [2**DEPTH_I];
    logic [WIDTH_D-1:0] mem_d [2**DEPTH_D];

    // Full 32-bit range checks so out-of-window addresses never alias.
    assign i_off    = ld_addr - I_BASE;
    assign ld_d_hit = ld_addr < 32'(2**DEPTH_D);
    assign ld_i_hit = (ld_addr >= I_BASE) && (i_off < 32'(2**DEPTH_I));

    assign mi_addr  = master ? cpu_i_addr : i_off[DEPTH_I-1:0];
    assign mi_we    = !master && commit && ld_i_hit;
    assign md_addr  = master ? cpu_d_addr  : ld_addr[DEPTH_D-1:0];
    assign md_wdata = master ? cpu_d_wdata : ld_data[WIDTH_D-1:0];
    assign md_we    = master ? cpu_d_we    : (commit && ld_d_hit);

    // Contents are deliberately not reset so a loaded image survives reset.
    always_ff @(posedge clk) begin
        if (mi_we) mem_i[mi_addr] <= ld_data;
        i_rdata <= mem_i[mi_addr];
    end

    always_ff @(posedge clk) begin
        if (md_we) mem_d[md_addr] <= md_wdata;
        d_rdata <= mem_d[md_addr];
    end

    // ---------------- CPU ----------------
    logic               cpu_rst;
    logic [4:0]         io_addr;
    logic [WIDTH_D-1:0] io_rdata, io_wdata;
    logic               io_we;

    assign cpu_rst = !reset || cpu_reset || !master;

    sc1_cpu #(.WIDTH_D(WIDTH_D), .DEPTH_I(DEPTH_I), .DEPTH_D(DEPTH_D)) u_cpu (
        .clk      (clk),
        .reset    (cpu_rst),
        .resume   (resume),
        .i_addr   (cpu_i_addr),
        .i_data   (i_rdata),
        .d_addr   (cpu_d_addr),
        .d_rdata  (d_rdata),
        .d_wdata  (cpu_d_wdata),
        .d_we     (cpu_d_we),
        .io_addr  (io_addr),
        .io_rdata (io_rdata),
        .io_wdata (io_wdata),
        .io_we    (io_we)
    );

    // ---------------- IO registers ----------------
    logic [WIDTH_D-1:0] io_reg_w [32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 32; k++) io_reg_w[k] <= '0;
        end else if (io_we) begin
            io_reg_w[io_addr] <= io_wdata;
        end
    end

    assign io_rdata      = io_reg_w[io_addr];
    assign pins.led      = io_reg_w[0][9:0];
    assign pins.uart_txd = 1'b1;
endmodule

// File: tb/tb_sc1_soc.sv
// tb_sc1_soc -- directed bench for sc1_soc: UART loader packets, address
// decode boundaries, master ownership, glitch rejection, reset abort and a
// tiny CPU program that drives the LEDs.
module tb_sc1_soc;
    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 125000;
    localparam int P      = CLK_HZ / BAUD;   // 8 clocks per bit

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   errors  = 0;
    int   checks  = 0;
    int   strobes = 0;
    int   s0;

    sc1_soc_if pins();

    sc1_soc #(
        .UART_CLK_HZ(CLK_HZ), .UART_SCLK_HZ(BAUD), .WIDTH_D(32),
        .DEPTH_I(6), .DEPTH_D(6), .DEPTH_V(17)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pins  (pins)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dut.byte_valid) strobes++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        pins.uart_rxd = v;
        repeat (P) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(1'b1);
    endtask

    task automatic send_pkt(input logic [31:0] a, input logic [31:0] d, input logic [7:0] e);
        send_byte(8'hAA);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
        send_byte(e);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        pins.uart_rxd = 1'b1;
        @(negedge clk);
        repeat (4) @(negedge clk);
        chk("led_in_reset", 32'(pins.led), 32'h0);
        chk("txd_in_reset", 32'(pins.uart_txd), 32'h1);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("led_after_reset", 32'(pins.led), 32'h0);
        chk("txd_idle", 32'(pins.uart_txd), 32'h1);
        chk("cpu_held", 32'(dut.cpu_rst), 32'h1);
        chk("master_rst", 32'(dut.master), 32'h0);
        chk("resume_rst", 32'(dut.resume), 32'h0);

        // one-clock low pulse must not start a byte
        s0 = strobes;
        pins.uart_rxd = 1'b0;
        @(negedge clk);
        pins.uart_rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_no_strobe", 32'(strobes - s0), 32'h0);

        // stray byte in IDLE: received once, ignored by loader
        s0 = strobes;
        send_byte(8'h13);
        chk("byte_strobe", 32'(strobes - s0), 32'h1);
        chk("rx_byte", 32'(dut.rx_byte), 32'h13);

        send_pkt(32'h0000_4000, 32'h0000_0001, 8'h55);
        chk("mem_i0_load", dut.mem_i[0], 32'h0000_0001);

        send_pkt(32'h0000_0005, 32'hCAFE_0005, 8'h55);
        chk("mem_d5_first", dut.mem_d[5], 32'hCAFE_0005);
        send_pkt(32'h0000_0005, 32'h1234_5678, 8'h54);
        chk("mem_d5_bad_end", dut.mem_d[5], 32'hCAFE_0005);
        send_pkt(32'h0000_0005, 32'h1234_5678, 8'h55);
        chk("mem_d5_good", dut.mem_d[5], 32'h1234_5678);

        send_pkt(32'h0000_003F, 32'h0000_003F, 8'h55);
        chk("mem_d_top", dut.mem_d[63], 32'h0000_003F);
        send_pkt(32'h0000_0045, 32'h0000_0BAD, 8'h55);
        chk("mem_d_oob", dut.mem_d[5], 32'h1234_5678);
        send_pkt(32'h0000_4040, 32'h0000_0BAD, 8'h55);
        chk("mem_i_oob", dut.mem_i[0], 32'h0000_0001);
        send_pkt(32'h0000_4001, 32'h1111_1111, 8'h55);
        chk("mem_i1_load", dut.mem_i[1], 32'h1111_1111);

        // reset in the middle of a packet aborts it
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h00);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hAB);
        send_byte(8'hCD);
        send_byte(8'hEF);
        send_byte(8'h01);
        send_byte(8'h55);
        repeat (2) @(negedge clk);
        chk("mid_pkt_reset", dut.mem_d[5], 32'h1234_5678);
        chk("ram_kept", dut.mem_i[1], 32'h1111_1111);

        // master = 1 locks the loader out of the RAMs
        send_pkt(32'h0000_5002, 32'h1, 8'h55);
        chk("master_set", 32'(dut.master), 32'h1);
        chk("cpu_still_held", 32'(dut.cpu_rst), 32'h1);
        send_pkt(32'h0000_4001, 32'hDEAD_BEEF, 8'h55);
        chk("mem_i1_locked", dut.mem_i[1], 32'h1111_1111);
        send_pkt(32'h0000_5002, 32'h0, 8'h55);
        chk("master_clr", 32'(dut.master), 32'h0);

        // program: HALT; LDI 0x3FF; STIO 0; JMP 3
        send_pkt(32'h0000_4000, 32'hF000_0000, 8'h55);
        send_pkt(32'h0000_4001, 32'h1000_03FF, 8'h55);
        send_pkt(32'h0000_4002, 32'h2000_0000, 8'h55);
        send_pkt(32'h0000_4003, 32'h7000_0003, 8'h55);
        chk("prog_word1", dut.mem_i[1], 32'h1000_03FF);
        send_pkt(32'h0000_5000, 32'h0, 8'h55);
        chk("cpu_held_by_master", 32'(dut.cpu_rst), 32'h1);
        send_pkt(32'h0000_5002, 32'h1, 8'h55);
        chk("cpu_running", 32'(dut.cpu_rst), 32'h0);
        chk("led_halted", 32'(pins.led), 32'h0);
        send_pkt(32'h0000_5001, 32'h1, 8'h55);
        send_pkt(32'h0000_5001, 32'h0, 8'h55);
        chk("led_program", 32'(pins.led), 32'h3FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sc1_soc.md
SC1_SOC -- requirements
Module: sc1_soc

Interface
REQ-001 SHALL have parameter UART_CLK_HZ, default 50000000; system clock frequency in Hz.
REQ-002 SHALL have parameter UART_SCLK_HZ, default 115200; UART bit rate; P = UART_CLK_HZ/UART_SCLK_HZ clocks per bit, P >= 2.
REQ-003 SHALL have parameter WIDTH_D, default 32; data word width.
REQ-004 SHALL have parameter DEPTH_I, default 12; log2 of instruction memory words.
REQ-005 SHALL have parameter DEPTH_D, default 12; log2 of data memory words.
REQ-006 SHALL have parameter DEPTH_V, default 17; reserved for video, unused in this configuration.
REQ-007 SHALL have port clk, input, 1 bit; the single clock, all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit; asynchronous, active-low reset.
REQ-009 SHALL have port uart_rxd, input, 1 bit; UART receive line, idle high.
REQ-010 SHALL have port uart_txd, output, 1 bit; UART transmit line, tied to constant 1 (idle).
REQ-011 SHALL have port led, output, 10 bits; LED drive.
REQ-012 SHALL build with audio, VGA and I2C options disabled; those ports are absent.

Function
REQ-013 SHALL synchronise uart_rxd through 2 flip-flops before any use.
REQ-014 UART receiver SHALL use 8N1 framing, LSB first; frame starts on a synchronised falling edge.
REQ-015 UART receiver SHALL recheck the line low at P/2 clocks; if high, treat as a glitch and return to idle.
REQ-016 UART receiver SHALL sample data bits every P clocks and the stop bit P clocks after bit 7.
REQ-017 Stop bit = 0 SHALL discard the byte.
REQ-018 A valid byte SHALL produce a 1-cycle byte_valid strobe.
REQ-019 Loader FSM states SHALL be IDLE, A0..A3, D0..D3, END.
REQ-020 In IDLE, byte 0xAA SHALL advance to A0; any other byte is ignored.
REQ-021 A0..A3 SHALL capture the 32-bit address, little-endian (A0 = bits 7:0).
REQ-022 D0..D3 SHALL capture the 32-bit data, little-endian.
REQ-023 In END, byte 0x55 SHALL commit the write on the next clock; any other byte SHALL drop the packet; both cases return to IDLE.
REQ-024 Commit decode: 0x0000..2^DEPTH_D-1 SHALL write mem_d[addr] = data[WIDTH_D-1:0], only when master = 0.
REQ-025 Commit decode: 0x4000..0x4000+2^DEPTH_I-1 SHALL write mem_i[addr-0x4000] = data[31:0], only when master = 0.
REQ-026 Commit decode: 0x5000 SHALL set cpu_reset = data[0]; 0x5001 SHALL set resume = data[0]; 0x5002 SHALL set master = data[0].
REQ-027 Committed writes to all other addresses SHALL be ignored without side effects.
REQ-028 mem_i SHALL be 2^DEPTH_I x 32 and mem_d SHALL be 2^DEPTH_D x WIDTH_D single-port RAMs with registered read (1-cycle latency).
REQ-029 When master = 1, the CPU SHALL own the RAM address and write ports; when master = 0, the loader SHALL own them.
REQ-030 Instantiate existing core sc1_cpu with ports: clk, reset (active-high), resume, i_addr[DEPTH_I-1:0], i_data[31:0], d_addr[DEPTH_D-1:0], d_rdata, d_wdata, d_we, io_addr[4:0], io_rdata, io_wdata, io_we.
REQ-031 CPU reset input SHALL be asserted while reset is low OR cpu_reset = 1 OR master = 0.
REQ-032 The CPU SHALL see resume as a level.
REQ-033 IO block SHALL hold 32 x WIDTH_D registers io_reg_w, written when io_we = 1.
REQ-034 io_rdata SHALL return io_reg_w[io_addr] combinationally.
REQ-035 led SHALL equal io_reg_w[0][9:0].
REQ-036 A loader commit and a CPU access in the same cycle SHALL never conflict; ownership is decided solely by master.

Reset
REQ-037 While reset is low: loader FSM and UART receiver SHALL go to idle.
REQ-038 While reset is low: cpu_reset SHALL be 1, resume 0, master 0.
REQ-039 While reset is low: all io_reg_w SHALL be 0, so led = 0; uart_txd SHALL be 1.
REQ-040 RAM contents SHALL NOT be cleared by reset.
REQ-041 Reset asserted mid-packet SHALL abort the packet; no write occurs.

Verification
REQ-042 Release reset, rxd idle: led = 0, uart_txd = 1, CPU held in reset.
REQ-043 Send AA 00 40 00 00 01 00 00 00 55: mem_i[0] = 0x00000001 within 2 clocks after the END byte's stop bit.
REQ-044 Send AA 05 00 00 00 78 56 34 12 54 (bad end byte): mem_d[5] unchanged; a following valid packet to 0x0005 with data 0x12345678 writes it.
REQ-045 Set master = 1 via 0x5002, then send packet to 0x4001 with data 0xDEADBEEF: mem_i[1] unchanged.
REQ-046 Glitch test: rxd low for 1 clock when P >= 4: no byte_valid strobe.
REQ-047 Load a program that writes 0x3FF to IO address 0; write master = 1, cpu_reset = 0, pulse resume: led = 0x3FF.
